decentering: RTL

//  Inverse of the whitening-stage centering step. It adds the per-channel mean back onto

---
 rtl/decentering.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/decentering.sv
// Decentering stage: adds per-frame latched channel means back onto signed samples
// and saturates the result into the unsigned DATA_W range, NUM_SAMPLES per frame.
module decentering #(
    parameter int unsigned DATA_W      = 26,
    parameter int unsigned NUM_SAMPLES = 1024,
    parameter int unsigned CNT_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              GO,
    input  logic [DATA_W-1:0] mean1,
    input  logic [DATA_W-1:0] mean2,
    input  logic [DATA_W-1:0] mean3,
    input  logic [DATA_W-1:0] mean4,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x1_in,
    input  logic [DATA_W-1:0] x2_in,
    input  logic [DATA_W-1:0] x3_in,
    input  logic [DATA_W-1:0] x4_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x1_out,
    output logic [DATA_W-1:0] x2_out,
    output logic [DATA_W-1:0] x3_out,
    output logic [DATA_W-1:0] x4_out,
    output logic              busy,
    output logic              done,
    output logic              sat_flag
);
    localparam int unsigned SUM_W = DATA_W + 2;
    localparam int unsigned NCH   = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mean_q  [NCH];
    logic [DATA_W-1:0] x_in_a  [NCH];
    logic [DATA_W-1:0] x_out_q [NCH];
    logic [SUM_W-1:0]  sum_c   [NCH];
    logic [DATA_W-1:0] res_c   [NCH];
    logic [NCH-1:0]    sat_c;
    logic              accept;
    logic              go_accept;
    logic              out_fire;
    logic              last_accept;

    assign x_in_a[0] = x1_in;
    assign x_in_a[1] = x2_in;
    assign x_in_a[2] = x3_in;
    assign x_in_a[3] = x4_in;
    assign x1_out    = x_out_q[0];
    assign x2_out    = x_out_q[1];
    assign x3_out    = x_out_q[2];
    assign x4_out    = x_out_q[3];

    assign accept      = in_valid & in_ready;
    assign go_accept   = (state == S_IDLE) & GO;
    assign out_fire    = out_valid & out_ready;
    assign last_accept = accept & (count == CNT_W'(NUM_SAMPLES - 1));

    // Signed sample plus unsigned mean in a two-bit-wider signed sum, then clamp.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum_c[i] = {{2{x_in_a[i][DATA_W-1]}}, x_in_a[i]} + {2'b00, mean_q[i]};
            if (sum_c[i][SUM_W-1]) begin
                res_c[i] = '0;
                sat_c[i] = 1'b1;
            end else if (sum_c[i][DATA_W]) begin
                res_c[i] = '1;
                sat_c[i] = 1'b1;
            end else begin
                res_c[i] = sum_c[i][DATA_W-1:0];
                sat_c[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (GO) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   if (last_accept) state_nx = S_DRAIN;
            S_DRAIN: if (!out_valid || out_ready) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Single output register stage: accept is allowed whenever it is empty or draining.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_LOAD:  busy = 1'b1;
            S_RUN: begin
                busy     = 1'b1;
                in_ready = ~out_valid | out_ready;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                mean_q[i]  <= '0;
                x_out_q[i] <= '0;
            end
        end else begin
            if (go_accept) begin
                count     <= '0;
                sat_flag  <= 1'b0;
                mean_q[0] <= mean1;
                mean_q[1] <= mean2;
                mean_q[2] <= mean3;
                mean_q[3] <= mean4;
            end
            if (accept) begin
                count     <= count + CNT_W'(1);
                out_valid <= 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    x_out_q[i] <= res_c[i];
                end
                if (|sat_c) begin
                    sat_flag <= 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
